// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 size codes and FSM encoding.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } lsu_state_t;

  // Halfwords must be 2-byte aligned and words 4-byte aligned; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] byte_off);
    logic mis;
    mis = 1'b0;
    case (funct3)
      LSU_H, LSU_HU: mis = byte_off[0];
      LSU_W:         mis = (byte_off != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half out of the memory word and extend it for loads.
  always_comb begin
    byte_sel  = word_in[{byte_off, 3'b000} +: 8];
    half_sel  = byte_off[1] ? word_in[31:16] : word_in[15:0];
    load_data = word_in;
    case (funct3)
      LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_data = {24'h0, byte_sel};
      LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_data = {16'h0, half_sel};
      default: load_data = word_in;
    endcase
  end

  // Overlay the low store bits onto the addressed lane of the word just read.
  always_comb begin
    merged_word = word_in;
    case (funct3)
      LSU_B, LSU_BU: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
      LSU_H, LSU_HU: begin
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      default:       merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores via read-modify-write.
// Latency: load/SW done 3 cycles after accept, SB/SH 5, misaligned 1; +1 per missing response.
// Backpressure: lsu_busy blocks new commands; WAIT states hold the strobe until response or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misaligned,
  output logic        lsu_error,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        response
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_nxt;
  logic        cmd_we;
  logic [2:0]  cmd_funct3;
  logic [1:0]  cmd_off;
  logic [31:0] cmd_wdata;
  logic [7:0]  wait_cnt;
  logic        accept, misaligned_req, word_store_req;
  logic        in_wait, timed_out, rd_hit, wr_hit;
  logic [31:0] lane_load, lane_merge;

  assign accept         = (state == ST_IDLE) && lsu_req;
  assign misaligned_req = is_misaligned(lsu_funct3, lsu_addr[1:0]);
  assign word_store_req = lsu_we && (lsu_funct3 == LSU_W);
  assign in_wait        = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
  assign timed_out      = in_wait && !response && (wait_cnt == TIMEOUT_LAST);
  assign rd_hit         = (state == ST_RD_WAIT) && response;
  assign wr_hit         = (state == ST_WR_WAIT) && response;

  lsu_lane u_lane (
    .funct3      (cmd_funct3),
    .byte_off    (cmd_off),
    .word_in     (read_data),
    .store_data  (cmd_wdata),
    .load_data   (lane_load),
    .merged_word (lane_merge)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; response is only trusted in WAIT since it may echo the previous strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && !misaligned_req)
          state_nxt = word_store_req ? ST_WR_REQ : ST_RD_REQ;
      end
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (response)       state_nxt = cmd_we ? ST_WR_REQ : ST_IDLE;
        else if (timed_out) state_nxt = ST_IDLE;
      end
      ST_WR_REQ:  state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (response || timed_out) state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    memory_read  = (state == ST_RD_REQ) || (state == ST_RD_WAIT);
    memory_write = (state == ST_WR_REQ) || (state == ST_WR_WAIT);
    lsu_busy     = (state != ST_IDLE);
  end

  // WAIT-cycle counter, restarted by the REQ state preceding each WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       wait_cnt <= 8'h0;
    else if (state == ST_RD_REQ || state == ST_WR_REQ) wait_cnt <= 8'h0;
    else if (in_wait)                                 wait_cnt <= wait_cnt + 8'h1;
  end

  // Command latch, word address and the word to be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_we     <= 1'b0;
      cmd_funct3 <= 3'b000;
      cmd_off    <= 2'b00;
      cmd_wdata  <= 32'h0;
      address    <= 32'h0;
      write_data <= 32'h0;
    end else if (accept) begin
      cmd_we     <= lsu_we;
      cmd_funct3 <= lsu_funct3;
      cmd_off    <= lsu_addr[1:0];
      cmd_wdata  <= lsu_wdata;
      address    <= {lsu_addr[31:2], 2'b00};
      if (word_store_req) write_data <= lsu_wdata;
    end else if (rd_hit && cmd_we) begin
      write_data <= lane_merge;
    end
  end

  // Completion pulse with status; load data is only replaced on a successful load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_done       <= 1'b0;
      lsu_misaligned <= 1'b0;
      lsu_error      <= 1'b0;
      lsu_rdata      <= 32'h0;
    end else begin
      lsu_done       <= 1'b0;
      lsu_misaligned <= 1'b0;
      lsu_error      <= 1'b0;
      if (accept && misaligned_req) begin
        lsu_done       <= 1'b1;
        lsu_misaligned <= 1'b1;
      end
      if (rd_hit && !cmd_we) begin
        lsu_done  <= 1'b1;
        lsu_rdata <= lane_load;
      end
      if (wr_hit) lsu_done <= 1'b1;
      if (timed_out) begin
        lsu_done  <= 1'b1;
        lsu_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle registered-response memory model.
// Latency: per-cycle strobe/done traces compared against hand-derived bit patterns.
// Backpressure: responder can be muted to exercise the timeout path.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misaligned;
  logic        lsu_error;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        response;

  logic [31:0] mem [0:63];
  logic        resp_en;
  int          total;
  int          bad;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req        (lsu_req),
    .lsu_we         (lsu_we),
    .lsu_funct3     (lsu_funct3),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_busy       (lsu_busy),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .lsu_misaligned (lsu_misaligned),
    .lsu_error      (lsu_error),
    .memory_read    (memory_read),
    .memory_write   (memory_write),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .response       (response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data = memory_read ? mem[address[7:2]] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) response <= 1'b0;
    else        response <= resp_en & (memory_read | memory_write);
  end

  always @(posedge clk) begin
    if (rst_n && memory_write) mem[address[7:2]] <= write_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and record per-cycle traces; bit c = cycle c after acceptance.
  task automatic run_cmd(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ncyc,
                         output logic [15:0] rd, output logic [15:0] wr, output logic [15:0] dn,
                         output logic [15:0] mis, output logic [15:0] err,
                         output logic [31:0] rdat, output logic [31:0] adr1);
    rd = '0; wr = '0; dn = '0; mis = '0; err = '0; rdat = 32'h0; adr1 = 32'h0;
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    step();
    lsu_req = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      rd[c]  = memory_read;
      wr[c]  = memory_write;
      dn[c]  = lsu_done;
      mis[c] = lsu_misaligned;
      err[c] = lsu_error;
      if (lsu_done) rdat = lsu_rdata;
      if (c == 1) adr1 = address;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({lsu_busy, lsu_done, lsu_misaligned, lsu_error, memory_read, memory_write} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {lsu_busy, lsu_done, lsu_misaligned, lsu_error, memory_read, memory_write});
    end
    total++;
    if ({lsu_rdata, address, write_data} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h want zeros", lsu_rdata, address, write_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    logic [15:0] rd, wr, dn, mis, err;
    logic [31:0] rdat, adr1;
    mem[4] = 32'hDEADBEEF;
    run_cmd(1'b0, 3'b010, 32'h10, 32'h0, 6, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (rd !== 16'h0006 || wr !== 16'h0000) begin
      bad++; $display("FAIL lw_strobes: got rd=%h wr=%h want rd=0006 wr=0000", rd, wr);
    end
    total++;
    if (dn !== 16'h0008 || mis !== 16'h0 || err !== 16'h0) begin
      bad++; $display("FAIL lw_done: got dn=%h mis=%h err=%h want 0008 0 0", dn, mis, err);
    end
    total++;
    if (rdat !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_data: got %h want deadbeef", rdat);
    end
    total++;
    if (adr1 !== 32'h10) begin
      bad++; $display("FAIL lw_address: got %h want 00000010", adr1);
    end
  endtask

  task automatic test_sub_loads();
    logic [15:0] rd, wr, dn, mis, err;
    logic [31:0] rdat, adr1;
    mem[4] = 32'h80FF7F01;
    run_cmd(1'b0, 3'b000, 32'h13, 32'h0, 5, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (rdat !== 32'hFFFFFF80 || dn !== 16'h0008 || adr1 !== 32'h10) begin
      bad++; $display("FAIL lb: got data=%h dn=%h adr=%h want ffffff80 0008 00000010", rdat, dn, adr1);
    end
    run_cmd(1'b0, 3'b100, 32'h13, 32'h0, 5, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (rdat !== 32'h00000080 || dn !== 16'h0008) begin
      bad++; $display("FAIL lbu: got data=%h dn=%h want 00000080 0008", rdat, dn);
    end
    run_cmd(1'b0, 3'b001, 32'h12, 32'h0, 5, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (rdat !== 32'hFFFF80FF || dn !== 16'h0008) begin
      bad++; $display("FAIL lh: got data=%h dn=%h want ffff80ff 0008", rdat, dn);
    end
    run_cmd(1'b0, 3'b101, 32'h10, 32'h0, 5, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (rdat !== 32'h00007F01) begin
      bad++; $display("FAIL lhu: got data=%h want 00007f01", rdat);
    end
  endtask

  task automatic test_sub_stores();
    logic [15:0] rd, wr, dn, mis, err;
    logic [31:0] rdat, adr1;
    mem[8] = 32'h11223344;
    run_cmd(1'b1, 3'b000, 32'h21, 32'h123456AB, 7, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (rd !== 16'h0006 || wr !== 16'h0018) begin
      bad++; $display("FAIL sb_strobes: got rd=%h wr=%h want rd=0006 wr=0018", rd, wr);
    end
    total++;
    if (dn !== 16'h0020 || err !== 16'h0) begin
      bad++; $display("FAIL sb_done: got dn=%h err=%h want 0020 0", dn, err);
    end
    total++;
    if (mem[8] !== 32'h1122AB44) begin
      bad++; $display("FAIL sb_word: got %h want 1122ab44", mem[8]);
    end
    mem[9] = 32'h11223344;
    run_cmd(1'b1, 3'b001, 32'h26, 32'h0000BEEF, 7, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (mem[9] !== 32'hBEEF3344 || dn !== 16'h0020) begin
      bad++; $display("FAIL sh_word: got %h dn=%h want beef3344 0020", mem[9], dn);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, wr, dn;
    logic [31:0] rdat;
    rd = '0; wr = '0; dn = '0; rdat = 32'h0;
    mem[12] = 32'h0;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; lsu_addr = 32'h30; lsu_wdata = 32'hCAFEF00D;
    step();
    lsu_req = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      rd[c] = memory_read;
      wr[c] = memory_write;
      dn[c] = lsu_done;
      if (lsu_done) rdat = lsu_rdata;
      if (c == 3) begin
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h30; lsu_wdata = 32'h0;
      end
      step();
      lsu_req = 1'b0;
    end
    total++;
    if (wr !== 16'h0006 || rd !== 16'h0030) begin
      bad++; $display("FAIL b2b_strobes: got wr=%h rd=%h want wr=0006 rd=0030", wr, rd);
    end
    total++;
    if (dn !== 16'h0048) begin
      bad++; $display("FAIL b2b_done: got %h want 0048", dn);
    end
    total++;
    if (rdat !== 32'hCAFEF00D) begin
      bad++; $display("FAIL b2b_data: got %h want cafef00d", rdat);
    end
  endtask

  task automatic test_misaligned();
    logic [15:0] rd, wr, dn, mis, err;
    logic [31:0] rdat, adr1;
    run_cmd(1'b0, 3'b010, 32'h02, 32'h0, 4, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (dn !== 16'h0002 || mis !== 16'h0002 || (rd | wr) !== 16'h0) begin
      bad++; $display("FAIL lw_misaligned: got dn=%h mis=%h rd=%h wr=%h want 0002 0002 0 0", dn, mis, rd, wr);
    end
    run_cmd(1'b1, 3'b001, 32'h03, 32'h1234, 4, rd, wr, dn, mis, err, rdat, adr1);
    total++;
    if (dn !== 16'h0002 || mis !== 16'h0002 || (rd | wr) !== 16'h0) begin
      bad++; $display("FAIL sh_misaligned: got dn=%h mis=%h rd=%h wr=%h want 0002 0002 0 0", dn, mis, rd, wr);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] rd, wr, dn, mis, err;
    logic [31:0] rdat, adr1;
    resp_en = 1'b0;
    run_cmd(1'b0, 3'b010, 32'h10, 32'h0, 9, rd, wr, dn, mis, err, rdat, adr1);
    resp_en = 1'b1;
    total++;
    if (rd !== 16'h003E || dn !== 16'h0040 || err !== 16'h0040) begin
      bad++; $display("FAIL timeout: got rd=%h dn=%h err=%h want 003e 0040 0040", rd, dn, err);
    end
    total++;
    if (rdat !== 32'hCAFEF00D) begin
      bad++; $display("FAIL timeout_rdata_hold: got %h want cafef00d", rdat);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    resp_en = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h10;
    step();
    lsu_req = 1'b0;
    step();
    total++;
    if (memory_read !== 1'b1 || lsu_busy !== 1'b1) begin
      bad++; $display("FAIL mid_pre: got read=%b busy=%b want 1 1", memory_read, lsu_busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({memory_read, memory_write, lsu_busy, lsu_done} !== 4'b0) begin
      bad++; $display("FAIL mid_strobes: got %b want 0000", {memory_read, memory_write, lsu_busy, lsu_done});
    end
    total++;
    if ({lsu_rdata, address, write_data} !== 96'h0) begin
      bad++; $display("FAIL mid_data: got %h %h %h want zeros", lsu_rdata, address, write_data);
    end
    resp_en = 1'b1;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (lsu_done || memory_read || memory_write) seen_done++;
      step();
    end
    total++;
    if (seen_done != 0) begin
      bad++; $display("FAIL mid_quiet: got %0d active cycles want 0", seen_done);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    resp_en = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    test_reset();
    test_lw();
    test_sub_loads();
    test_sub_stores();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's data-memory interface. Accepts one load or store command at a time from the execute stage and drives the word-wide `memory_read`/`memory_write`/`address`/`write_data` strobes of the data memory. It waits for the memory's registered `response` and returns sign- or zero-extended load data. Sub-word stores are performed as read-modify-write, because the memory has no byte enables.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of WAIT-state cycles before the access is abandoned with an error (8-bit counter; values 1–255).
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `lsu_req` input 1: command strobe; sampled only while `lsu_busy`=0.
- `lsu_we` input 1: 1 = store, 0 = load.
- `lsu_funct3` input 3: RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `lsu_addr` input 32: byte address.
- `lsu_wdata` input 32: store data, taken from the low bits for B/H.
- `lsu_busy` output 1: command in progress.
- `lsu_done` output 1: one-cycle completion pulse.
- `lsu_rdata` output 32: extended load data; valid when `lsu_done`=1, held until the next `lsu_done`.
- `lsu_misaligned` output 1: with `lsu_done`, address not aligned to the access size.
- `lsu_error` output 1: with `lsu_done`, timeout occurred.
- `memory_read` output 1: read strobe.
- `memory_write` output 1: write strobe.
- `address` output 32: always `{lsu_addr[31:2], 2'b00}` of the latched command.
- `write_data` output 32: full word to write.
- `read_data` input 32: combinational memory data; meaningful only while `memory_read`=1.
- `response` input 1: registered copy of last cycle's `memory_read | memory_write`.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- **Reset:** state IDLE. All outputs 0, including `lsu_rdata`.
- **IDLE + `lsu_req`:** latch the command.
  - Misaligned (H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0): stay IDLE and pulse `lsu_done` + `lsu_misaligned` next cycle. No strobe is issued.
  - Loads, and B/H stores: go to RD_REQ.
  - W store: go to WR_REQ.
- **REQ states:** assert the strobe. `response` is ignored here, because it may be stale (high one cycle after any prior strobe). Go to the matching WAIT state.
- **WAIT states:**
  - Keep the strobe asserted until `response`=1.
  - RD_WAIT on response, load: extract the lane selected by `addr[1:0]`, extend, and register into `lsu_rdata`; go to IDLE with `lsu_done`.
  - RD_WAIT on response, B/H store: merge the store byte/half into `read_data` at the lane, register the result into `write_data`, and go to WR_REQ.
  - WR_WAIT on response: go to IDLE with `lsu_done`.
- **Timeout:** counter cleared on entry to each WAIT state. When it reaches `TIMEOUT_CYCLES`, go to IDLE with `lsu_done` + `lsu_error`; `lsu_rdata` is unchanged.
- `memory_read` and `memory_write` are never asserted together.
- `lsu_busy` = (state ≠ IDLE). A new `lsu_req` may be accepted in the same cycle `lsu_done` is high.
- **Reset mid-operation:** strobes drop immediately and no `lsu_done` is produced. A partially issued write may already have been committed by the memory.

## Timing
Request accepted at edge 0.
- LW/LH/LB(U): `memory_read`=1 in cycles 1–2; `lsu_done` and data in cycle 3.
- SW: `memory_write`=1 in cycles 1–2; `lsu_done` in cycle 3.
- SB/SH: `memory_read` in cycles 1–2, `memory_write` in cycles 3–4 (the memory writes the same word twice, which is harmless); `lsu_done` in cycle 5.
- Misaligned: `lsu_done` in cycle 1.
- A slower responder extends each WAIT state one cycle per missing `response`.

## Structure
- Package `lsu_pkg`: funct3 constants (`LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`) and FSM state encoding.
- Sub-module `lsu_lane`: purely combinational. Load extraction/extension and store merge, from `funct3`, `addr[1:0]`, `word_in`, and `store_data`.
- The top level holds the FSM, command latch, timeout counter, and output registers.

## Test plan
- LW `0x10` with memory word `0xDEADBEEF` → `memory_read` high 2 cycles, `address`=`0x10`, `lsu_rdata`=`0xDEADBEEF` with `lsu_done` in cycle 3.
- LB / LBU `0x13` on word `0x80FF7F01` → `0xFFFFFF80` / `0x00000080`. LH `0x12` → `0xFFFF80FF`.
- SB `0x21`, data `0xAB`, memory `0x11223344` → read then write; final word `0x1122AB44`; `lsu_done` in cycle 5.
- SW back-to-back with LW, new `lsu_req` issued on the `lsu_done` cycle → the stale `response` is not taken as the LW acknowledge, and the LW returns the stored value.
- LW `0x02` and SH `0x03` → `lsu_misaligned`+`lsu_done` in cycle 1, no strobe ever asserted.
- Responder holding `response`=0 with `TIMEOUT_CYCLES`=4 → `lsu_error`+`lsu_done` after 4 WAIT cycles. Separately, `rst_n` low during RD_WAIT → strobes drop asynchronously and all outputs return to 0.
